// File: rtl/regfile_write_scheduler.sv
// Two-port register-file write scheduler: fixed-priority grant of up to two requests per cycle, registered port outputs.
// Optional starvation guard enabled by defining WSCHED_STARVE_GUARD_EN.
module regfile_write_scheduler #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hold,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]           write_port_1,
    output logic [DATA_W-1:0]           write_data_1,
    output logic [ADDR_W-1:0]           write_port_2,
    output logic [DATA_W-1:0]           write_data_2,
    output logic                        conflict
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("regfile_write_scheduler: illegal parameter value");
    end

    logic [ADDR_W-1:0] addr_a [NUM_REQ];
    logic [DATA_W-1:0] data_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign data_a[g] = req_data[g*DATA_W +: DATA_W];
    end

    logic [NUM_REQ-1:0] starving;

`ifdef WSCHED_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] wait_cnt_q [NUM_REQ];
    logic [CNT_W-1:0] wait_cnt_d [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            starving[i]   = (wait_cnt_q[i] >= CNT_W'(STARVE_LIMIT));
            if (!req_valid[i] || req_ready[i]) begin
                wait_cnt_d[i] = '0;
            end else if (!hold && (wait_cnt_q[i] != CNT_W'(STARVE_LIMIT))) begin
                wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end
`else
    assign starving = '0;
`endif

    logic              s1_found;
    logic              s2_found;
    logic [IDX_W-1:0]  s1_idx;
    logic [IDX_W-1:0]  s2_idx;
    logic [ADDR_W-1:0] s1_addr;
    logic              blocked;
    logic [NUM_REQ-1:0] grant;

    // Pass 0 scans starving requesters, pass 1 the rest; with the guard off only pass 0 sees any requester.
    // A same-address skip only counts as a conflict while slot 2 is still open; later skips are port exhaustion.
    always_comb begin
        s1_found = 1'b0;
        s2_found = 1'b0;
        s1_idx   = '0;
        s2_idx   = '0;
        s1_addr  = '0;
        blocked  = 1'b0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef WSCHED_STARVE_GUARD_EN
                if (req_valid[i] && (starving[i] == (p == 0))) begin
`else
                if (req_valid[i] && (p == 0)) begin
`endif
                    if (!s1_found) begin
                        s1_found = 1'b1;
                        s1_idx   = IDX_W'(i);
                        s1_addr  = addr_a[i];
                    end else if (!s2_found) begin
                        if ((addr_a[i] != s1_addr) || (addr_a[i] == '0)) begin
                            s2_found = 1'b1;
                            s2_idx   = IDX_W'(i);
                        end else begin
                            blocked = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (s1_found) grant[s1_idx] = 1'b1;
        if (s2_found) grant[s2_idx] = 1'b1;
    end

    assign req_ready = (reset && !hold) ? grant : '0;

    logic [ADDR_W-1:0] port1_q, port1_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [ADDR_W-1:0] port2_q, port2_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic              conflict_q, conflict_d;

    always_comb begin
        port1_d    = '0;
        data1_d    = '0;
        port2_d    = '0;
        data2_d    = '0;
        conflict_d = 1'b0;
        if (!hold) begin
            if (s1_found) begin
                port1_d = s1_addr;
                data1_d = data_a[s1_idx];
            end
            if (s2_found) begin
                port2_d = addr_a[s2_idx];
                data2_d = data_a[s2_idx];
            end
            conflict_d = blocked;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port1_q    <= '0;
            data1_q    <= '0;
            port2_q    <= '0;
            data2_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            port1_q    <= port1_d;
            data1_q    <= data1_d;
            port2_q    <= port2_d;
            data2_q    <= data2_d;
            conflict_q <= conflict_d;
        end
    end

    assign write_port_1 = port1_q;
    assign write_data_1 = data1_q;
    assign write_port_2 = port2_q;
    assign write_data_2 = data2_q;
    assign conflict     = conflict_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed, table-driven bench for regfile_write_scheduler (NUM_REQ=4, ADDR_W=5, DATA_W=64).
module tb_regfile_write_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic         hold;
    logic [3:0]   req_valid;
    logic [19:0]  req_addr;
    logic [255:0] req_data;
    logic [3:0]   req_ready;
    logic [4:0]   write_port_1;
    logic [63:0]  write_data_1;
    logic [4:0]   write_port_2;
    logic [63:0]  write_data_2;
    logic         conflict;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_write_scheduler #(
        .NUM_REQ      (4),
        .ADDR_W       (5),
        .DATA_W       (64),
        .STARVE_LIMIT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .write_port_1 (write_port_1),
        .write_data_1 (write_data_1),
        .write_port_2 (write_port_2),
        .write_data_2 (write_data_2),
        .conflict     (conflict)
    );

    typedef struct {
        logic         hold;
        logic [3:0]   valid;
        logic [19:0]  addr;
        logic [255:0] data;
        logic [3:0]   rdy;
        logic [4:0]   p1;
        logic [63:0]  d1;
        logic [4:0]   p2;
        logic [63:0]  d2;
        logic         conf;
    } vec_t;

    function automatic logic [19:0] pa(input logic [4:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [255:0] pd(input logic [63:0] d3, d2, d1, d0);
        return {d3, d2, d1, d0};
    endfunction

    function automatic vec_t mk(input logic h, input logic [3:0] v, input logic [19:0] a,
                                input logic [255:0] d, input logic [3:0] r,
                                input logic [4:0] p1, input logic [63:0] d1,
                                input logic [4:0] p2, input logic [63:0] d2, input logic c);
        vec_t t;
        t.hold = h; t.valid = v; t.addr = a; t.data = d; t.rdy = r;
        t.p1 = p1; t.d1 = d1; t.p2 = p2; t.d2 = d2; t.conf = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic [3:0] v, input logic [19:0] a, input logic [255:0] d);
        hold      = h;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
    endtask

    vec_t vecs [13];

    initial begin
        vecs[0]  = mk(0, 4'b1110, pa(7, 6, 5, 0), pd(64'h33, 64'h22, 64'h11, 0),
                      4'b0110, 5, 64'h11, 6, 64'h22, 0);
        vecs[1]  = mk(0, 4'b1000, pa(7, 6, 5, 0), pd(64'h33, 64'h22, 64'h11, 0),
                      4'b1000, 7, 64'h33, 0, 0, 0);
        vecs[2]  = mk(0, 4'b0111, pa(0, 4, 9, 9), pd(0, 64'hC, 64'hB, 64'hA),
                      4'b0101, 9, 64'hA, 4, 64'hC, 1);
        vecs[3]  = mk(0, 4'b0010, pa(0, 4, 9, 9), pd(0, 64'hC, 64'hB, 64'hA),
                      4'b0010, 9, 64'hB, 0, 0, 0);
        vecs[4]  = mk(0, 4'b0011, pa(0, 0, 0, 0), pd(0, 0, 64'hD1, 64'hD0),
                      4'b0011, 0, 64'hD0, 0, 64'hD1, 0);
        vecs[5]  = mk(1, 4'b0001, pa(0, 0, 0, 3), pd(0, 0, 0, 64'hE),
                      4'b0000, 0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 4'b0011, pa(0, 0, 3, 3), pd(0, 0, 64'hF, 64'hE),
                      4'b0000, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 4'b0001, pa(0, 0, 0, 3), pd(0, 0, 0, 64'hE),
                      4'b0000, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 4'b0011, pa(0, 0, 3, 3), pd(0, 0, 64'hF, 64'hE),
                      4'b0001, 3, 64'hE, 0, 0, 1);
        vecs[9]  = mk(0, 4'b1111, pa(4, 3, 2, 1), pd(64'h44, 64'h33, 64'h22, 64'h11),
                      4'b0011, 1, 64'h11, 2, 64'h22, 0);
        vecs[10] = mk(0, 4'b0111, pa(0, 0, 0, 8), pd(0, 64'h2, 64'h1, 64'h80),
                      4'b0011, 8, 64'h80, 0, 64'h1, 0);
        vecs[11] = mk(0, 4'b0000, pa(1, 2, 3, 4), pd(1, 2, 3, 4),
                      4'b0000, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 4'b1100, pa(5, 5, 0, 0), pd(64'hD3, 64'hD2, 0, 0),
                      4'b0100, 5, 64'hD2, 0, 0, 1);

        // Reset asserted with all requesters valid.
        reset = 1'b0;
        drive(0, 4'b1111, pa(4, 3, 2, 1), pd(64'h44, 64'h33, 64'h22, 64'h11));
        repeat (2) @(negedge clk);
        chk("reset_ready", 64'(req_ready), 0);
        chk("reset_p1", 64'(write_port_1), 0);
        chk("reset_d1", write_data_1, 0);
        chk("reset_p2", 64'(write_port_2), 0);
        chk("reset_d2", write_data_2, 0);
        chk("reset_conf", 64'(conflict), 0);

        // Grants appear combinationally as soon as reset is released.
        reset = 1'b1;
        #1;
        chk("release_ready", 64'(req_ready), 64'(4'b0011));
        @(posedge clk); #1;
        chk("release_p1", 64'(write_port_1), 1);
        chk("release_p2", 64'(write_port_2), 2);

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].hold, vecs[k].valid, vecs[k].addr, vecs[k].data);
            #1;
            chk($sformatf("v%0d_ready", k), 64'(req_ready), 64'(vecs[k].rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d_p1", k), 64'(write_port_1), 64'(vecs[k].p1));
            chk($sformatf("v%0d_d1", k), write_data_1, vecs[k].d1);
            chk($sformatf("v%0d_p2", k), 64'(write_port_2), 64'(vecs[k].p2));
            chk($sformatf("v%0d_d2", k), write_data_2, vecs[k].d2);
            chk($sformatf("v%0d_conf", k), 64'(conflict), 64'(vecs[k].conf));
        end

        // Back-to-back: r0 held valid is granted every cycle.
        @(negedge clk);
        drive(0, 4'b0001, pa(0, 0, 0, 12), pd(0, 0, 0, 64'h1234));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d_ready", c), 64'(req_ready), 1);
            chk($sformatf("b2b%0d_p1", c), 64'(write_port_1), 12);
        end

        // Asynchronous reset discards a latched write before it issues.
        @(posedge clk); #1;
        chk("midrst_pre_p1", 64'(write_port_1), 12);
        reset = 1'b0;
        #1;
        chk("midrst_p1", 64'(write_port_1), 0);
        chk("midrst_d1", write_data_1, 0);
        chk("midrst_ready", 64'(req_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 4'b0000, '0, '0);
        @(negedge clk);

        // Starvation: r0/r1 always win unless the guard promotes r3.
        drive(0, 4'b1011, pa(3, 0, 2, 1), pd(64'h333, 0, 64'h222, 64'h111));
        for (int c = 1; c <= 12; c++) begin
            #1;
`ifdef WSCHED_STARVE_GUARD_EN
            if (c == 9) chk($sformatf("starve_c%0d_ready", c), 64'(req_ready), 64'(4'b1001));
            else        chk($sformatf("starve_c%0d_ready", c), 64'(req_ready), 64'(4'b0011));
            if (c == 9) drive(0, 4'b0011, pa(0, 0, 2, 1), pd(0, 0, 64'h222, 64'h111));
`else
            chk($sformatf("starve_c%0d_ready", c), 64'(req_ready), 64'(4'b0011));
`endif
            @(negedge clk);
        end
        drive(0, 4'b0000, '0, '0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
Shares the register file's two write ports among NUM_REQ write requesters (cores or execution units), each using a valid/ready handshake. Each cycle it grants up to two requests by fixed priority, where a lower requester index means higher priority. It never presents the same nonzero register address on both ports. Grants are registered, and the block drives write_port_1/2 and write_data_1/2 of the register file one cycle after acceptance.

Parameters:
NUM_REQ, 4, number of requesters (legal 2..8)
ADDR_W, 5, register address width (32 registers)
DATA_W, 64, register data width
STARVE_LIMIT, 8, wait cycles before a requester is promoted (only used with the optional feature)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
hold  input  1  when 1, no grants are issued this cycle
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_W  packed destination register, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  combinational grant; a transfer occurs when valid && ready at the clk edge
write_port_1  output  ADDR_W  register file write address, port 1 (0 = no write)
write_data_1  output  DATA_W  register file write data, port 1
write_port_2  output  ADDR_W  register file write address, port 2 (0 = no write)
write_data_2  output  DATA_W  register file write data, port 2
conflict  output  1  registered pulse: a valid request was blocked by a same-address conflict

Behaviour:
- Reset (reset=0, asynchronous):
  - write_port_1/2 = 0, write_data_1/2 = 0, conflict = 0.
  - All wait counters cleared.
  - req_ready is forced to 0 while reset is low.
- Grant selection (combinational):
  - Scan requesters in priority order; the first valid request takes slot 1.
  - Continue scanning; the next valid request whose addr differs from slot 1's addr takes slot 2.
  - Exception: two addr-0 requests do not conflict. Both may be granted; they are harmless because port addr 0 means no write.
  - At most two grants per cycle. req_ready[i] = 1 only for granted requesters.
  - hold=1 means req_ready = 0 for all requesters.
- Output register, 1-cycle latency:
  - Slot 1 is latched into write_port_1/write_data_1 and slot 2 into write_port_2/write_data_2 at the granting edge.
  - The register file writes at the following edge.
  - An empty slot drives addr 0 and data 0.
  - A single grant always uses port 1.
- Same-address requests:
  - Only the higher-priority request is granted; the lower one stays pending with req_ready=0.
  - The requester must hold valid, addr and data stable until it is granted.
  - conflict is registered high for one cycle for each cycle this occurs. It is 0 under hold.
- Requesters beyond the second valid one are simply not ready; conflict is not asserted for pure port exhaustion.
- Back-to-back: a requester holding valid may be granted every cycle.
- No ordering is guaranteed across requesters to the same register beyond priority; same-cycle writes never collide.
- Reset mid-operation: any latched but unissued write is discarded (ports return to 0).

Optional Feature:
Macro WSCHED_STARVE_GUARD_EN.
- Defined:
  - Per-requester wait counter, width clog2(STARVE_LIMIT+1), saturating.
  - The counter increments each cycle valid && !ready && !hold.
  - It clears on grant or when valid=0; it holds its value under hold.
  - A requester with counter >= STARVE_LIMIT is "starving". Starving requesters are scanned first (lower index first), then non-starving ones.
  - Conflict rules are unchanged, except that a starving requester wins a same-address conflict against a non-starving one.
- Undefined: pure fixed priority; no counters are instantiated.

Test Plan:
1. Reset: hold reset=0 while req_valid=4'b1111 -> req_ready=0, write_port_1/2=0 and data=0. Release reset -> grants begin the same cycle.
2. Priority: req_valid=4'b1110, addrs {r3:7, r2:6, r1:5} -> req_ready=4'b0110. Next cycle write_port_1=5 with r1 data and write_port_2=6 with r2 data. r3 is granted in the following cycle if r1 and r2 drop valid.
3. Conflict: r0 addr=9 data=64'hA, r1 addr=9 data=64'hB, r2 addr=4 -> req_ready=4'b0101, write_port_1=9/64'hA, write_port_2=4, conflict=1. Next cycle r1 is granted and write_port_1=9/64'hB.
4. Zero address: r0 and r1 both addr=0 -> both ready, write_port_1=write_port_2=0, conflict=0.
5. Hold: hold=1 for 3 cycles with r0 valid -> req_ready=0 and ports 0 throughout. First cycle after hold drops -> r0 is granted.
6. Starvation (WSCHED_STARVE_GUARD_EN, STARVE_LIMIT=8): r0 and r1 valid every cycle, r3 valid with a distinct addr -> r3 is granted on the 9th cycle of waiting, ahead of r1. Without the macro, r3 is never granted.
